// File: rtl/cd4017_decade_decoder.sv
// Clocked decade counter with a registered one-hot decimal decoder (CD4017/CD4028 style).
// A BCD state is loaded or stepped and then expanded to a 10-bit one-hot output.
// Out-of-range loads raise a sticky error flag and blank the decoded output.
// Every output comes straight from a register; the next-state logic feeds those registers.
module cd4017_decade_decoder #(
    parameter int MODULUS = 10              // count length, legal range 2..10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_bcd,
    input  logic       i_load,
    input  logic       i_en,
    output logic [9:0] o,
    output logic       o_carry,
    output logic       o_tc,
    output logic       o_err
);

    // Constants narrowed to the 4-bit state width so all compares are 4-bit unsigned.
    localparam logic [3:0] MOD_VAL   = 4'(MODULUS);
    localparam logic [3:0] MOD_LAST  = 4'(MODULUS - 1);
    localparam logic [3:0] CARRY_LIM = 4'((MODULUS + 1) / 2);

    logic [3:0] q_q, q_d;
    logic       err_q, err_d;
    logic [9:0] o_q, o_d;
    logic       carry_q, carry_d;
    logic       tc_q, tc_d;

    // Next count state: load has priority over enable; enable is ignored while in error.
    always_comb begin
        q_d   = q_q;
        err_d = err_q;
        tc_d  = 1'b0;
        if (i_load) begin
            if (i_bcd < MOD_VAL) begin
                q_d   = i_bcd;
                err_d = 1'b0;
            end else begin
                q_d   = 4'd0;
                err_d = 1'b1;
            end
        end else if (i_en && !err_q) begin
            if (q_q == MOD_LAST) begin
                q_d  = 4'd0;
                tc_d = 1'b1;
            end else begin
                q_d = q_q + 4'd1;
            end
        end
    end

    // One-hot decode of the next state. Lines at or above MODULUS are tied low, and
    // an unreachable state value simply matches no line, leaving the output blank.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_decode
            if (gi < MODULUS) begin : g_live
                assign o_d[gi] = !err_d && (q_d == 4'(gi));
            end else begin : g_dead
                assign o_d[gi] = 1'b0;
            end
        end
    endgenerate

    // First half of the count cycle drives carry; blanked when in error.
    assign carry_d = !err_d && (q_d < CARRY_LIM);

    // State and output registers; reset acts immediately without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= 4'd0;
            err_q   <= 1'b0;
            o_q     <= 10'b00_0000_0001;
            carry_q <= 1'b1;
            tc_q    <= 1'b0;
        end else begin
            q_q     <= q_d;
            err_q   <= err_d;
            o_q     <= o_d;
            carry_q <= carry_d;
            tc_q    <= tc_d;
        end
    end

    assign o       = o_q;
    assign o_carry = carry_q;
    assign o_tc    = tc_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_cd4017_decade_decoder.sv
// Scoreboard bench for cd4017_decade_decoder: a MODULUS=10 and a MODULUS=6 instance share
// the same stimulus. The driver updates an arithmetic reference model and queues the
// expected outputs; a monitor pops and compares after every rising edge.
module tb_cd4017_decade_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] i_bcd = 4'd0;
    logic       i_load = 1'b0;
    logic       i_en = 1'b0;

    logic [9:0] o10, o6;
    logic       c10, c6, t10, t6, e10, e6;

    always #5 clk = ~clk;

    cd4017_decade_decoder #(.MODULUS(10)) dut10 (
        .clk(clk), .rst(rst), .i_bcd(i_bcd), .i_load(i_load), .i_en(i_en),
        .o(o10), .o_carry(c10), .o_tc(t10), .o_err(e10)
    );

    cd4017_decade_decoder #(.MODULUS(6)) dut6 (
        .clk(clk), .rst(rst), .i_bcd(i_bcd), .i_load(i_load), .i_en(i_en),
        .o(o6), .o_carry(c6), .o_tc(t6), .o_err(e6)
    );

    typedef struct {
        logic [9:0] o  [2];
        logic       c  [2];
        logic       t  [2];
        logic       e  [2];
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model: plain integer count and error flag per instance.
    int modv [2] = '{10, 6};
    int cnt  [2] = '{0, 0};
    bit err  [2] = '{0, 0};
    bit tc   [2] = '{0, 0};

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, want);
        end
    endtask

    task automatic model_step(input bit r, input bit ld, input int bcd, input bit en);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                cnt[k] = 0; err[k] = 0; tc[k] = 0;
            end else if (ld) begin
                tc[k] = 0;
                if (bcd < modv[k]) begin cnt[k] = bcd; err[k] = 0; end
                else begin cnt[k] = 0; err[k] = 1; end
            end else if (en && !err[k]) begin
                tc[k]  = (cnt[k] == modv[k] - 1);
                cnt[k] = (cnt[k] + 1) % modv[k];
            end else begin
                tc[k] = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        for (int k = 0; k < 2; k++) begin
            x.o[k] = err[k] ? 10'd0 : (10'd1 << cnt[k]);
            x.c[k] = !err[k] && (cnt[k] < (modv[k] + 1) / 2);
            x.t[k] = tc[k];
            x.e[k] = err[k];
        end
        return x;
    endfunction

    // Drive one cycle on the falling edge and queue what both instances must show after the next rising edge.
    task automatic cycle(input bit r, input bit ld, input int bcd, input bit en);
        @(negedge clk);
        rst    = r;
        i_load = ld;
        i_bcd  = 4'(bcd);
        i_en   = en;
        model_step(r, ld, bcd, en);
        exp_q.push_back(model_out());
    endtask

    // Monitor: compare every queued expectation one time unit after the rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                txn++;
                $display("txn %0d rst=%0b ld=%0b bcd=%0d en=%0b | m10 o=%h c=%0b t=%0b e=%0b | m6 o=%h c=%0b t=%0b e=%0b",
                         txn, rst, i_load, i_bcd, i_en, o10, c10, t10, e10, o6, c6, t6, e6);
                chk("o_m10",     o10,        x.o[0]);
                chk("carry_m10", 10'(c10),   10'(x.c[0]));
                chk("tc_m10",    10'(t10),   10'(x.t[0]));
                chk("err_m10",   10'(e10),   10'(x.e[0]));
                chk("o_m6",      o6,         x.o[1]);
                chk("carry_m6",  10'(c6),    10'(x.c[1]));
                chk("tc_m6",     10'(t6),    10'(x.t[1]));
                chk("err_m6",    10'(e6),    10'(x.e[1]));
            end
        end
    end

    // Stimulus: directed scenarios followed by random traffic.
    initial begin
        int wait_cycles;
        // reset held, then idle
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        // count 12 from reset (wrap on both instances)
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1);
        // load 7 with enable asserted, then one enabled step
        cycle(0, 1, 7, 1);
        cycle(0, 0, 0, 1);
        // illegal load, enable ignored, valid load recovers
        cycle(0, 1, 12, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
        cycle(0, 1, 3, 0);
        // load 6: legal for MODULUS=10, illegal for MODULUS=6
        cycle(0, 1, 6, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 9, 0);
        cycle(0, 1, 10, 0);
        cycle(0, 1, 0, 0);
        // count to 6 then assert reset between edges
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_o_m10",     o10,      10'h001);
        chk("async_carry_m10", 10'(c10), 10'd1);
        chk("async_o_m6",      o6,       10'h001);
        chk("async_err_m6",    10'(e6),  10'd0);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit r, ld, en;
            int bcd;
            r   = ($urandom_range(0, 49) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 3) != 0);
            bcd = $urandom_range(0, 15);
            cycle(r, ld, bcd, en);
        end
        // drain the scoreboard within a bounded number of cycles
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
